id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding front end of the execute stage. Captures decoded

---
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: pipeline control, decoded ID operands, forwarding sources
// and the forwarded EX-side outputs. The stage uses the slave view and the
// surrounding pipeline uses the master view.
interface id_ex_stage_if #(
   parameter int N  = 32,
   parameter int RW = 5
);
   // pipeline control
   logic          stall;
   logic          flush;
   // decoded instruction from ID
   logic          id_valid;
   logic [N-1:0]  id_pc;
   logic [RW-1:0] id_rs1;
   logic [RW-1:0] id_rs2;
   logic [RW-1:0] id_rd;
   logic [N-1:0]  id_rs1_data;
   logic [N-1:0]  id_rs2_data;
   logic [N-1:0]  id_imm;
   logic [3:0]    id_alu_sel;
   logic          id_alu_src;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          id_mem_write;
   // forwarding sources
   logic [RW-1:0] exmem_rd;
   logic          exmem_reg_write;
   logic [N-1:0]  exmem_result;
   logic [RW-1:0] memwb_rd;
   logic          memwb_reg_write;
   logic [N-1:0]  memwb_result;
   // stage outputs
   logic          load_use_stall;
   logic          ex_valid;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [3:0]    alu_sel;
   logic [4:0]    alu_shamt;
   logic [N-1:0]  ex_store_data;
   logic [RW-1:0] ex_rd;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic [N-1:0]  ex_pc;

   modport slave (
      input  stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, id_alu_sel, id_alu_src,
             id_reg_write, id_mem_read, id_mem_write,
             exmem_rd, exmem_reg_write, exmem_result,
             memwb_rd, memwb_reg_write, memwb_result,
      output load_use_stall, ex_valid, alu_a, alu_b, alu_sel, alu_shamt,
             ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
   );

   modport master (
      output stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, id_alu_sel, id_alu_src,
             id_reg_write, id_mem_read, id_mem_write,
             exmem_rd, exmem_reg_write, exmem_result,
             memwb_rd, memwb_reg_write, memwb_result,
      input  load_use_stall, ex_valid, alu_a, alu_b, alu_sel, alu_shamt,
             ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection. Forwarding is purely combinational on the
// registered instruction, so operands follow the live forwarding sources
// even while the stage is stalled.
module id_ex_stage #(
   parameter int N  = 32,
   parameter int RW = 5
) (
   input logic          clk,
   input logic          rst,      // asynchronous, active-low
   id_ex_stage_if.slave bus
);
   // ALU opcode encoding is shared with the decoder; ADD is the idle opcode.
   localparam logic [3:0] ALU_ADD = 4'd0;

   typedef struct packed {
      logic          valid;
      logic [N-1:0]  pc;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic [RW-1:0] rd;
      logic [N-1:0]  rs1_data;
      logic [N-1:0]  rs2_data;
      logic [N-1:0]  imm;
      logic [3:0]    alu_sel;
      logic          alu_src;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
   } ex_state_t;

   ex_state_t state_reg;
   ex_state_t state_next;
   ex_state_t bubble;
   ex_state_t captured;
   logic      load_use;

   // Load in EX whose destination is a source of the valid instruction in ID.
   always_comb begin
      load_use = state_reg.valid & state_reg.mem_read & (state_reg.rd != '0) &
                 bus.id_valid &
                 ((state_reg.rd == bus.id_rs1) | (state_reg.rd == bus.id_rs2));
   end

   // Bubble contents and the instruction image presented by ID.
   always_comb begin
      bubble             = '0;
      bubble.alu_sel     = ALU_ADD;
      captured           = '0;
      captured.valid     = bus.id_valid;
      captured.pc        = bus.id_pc;
      captured.rs1       = bus.id_rs1;
      captured.rs2       = bus.id_rs2;
      captured.rd        = bus.id_rd;
      captured.rs1_data  = bus.id_rs1_data;
      captured.rs2_data  = bus.id_rs2_data;
      captured.imm       = bus.id_imm;
      captured.alu_sel   = bus.id_alu_sel;
      captured.alu_src   = bus.id_alu_src;
      captured.reg_write = bus.id_reg_write;
      captured.mem_read  = bus.id_mem_read;
      captured.mem_write = bus.id_mem_write;
   end

   // Next-state priority: flush beats stall, stall beats the load-use bubble.
   always_comb begin
      state_next = state_reg;
      if (bus.flush) begin
         state_next = bubble;
      end else if (bus.stall) begin
         state_next = state_reg;
      end else if (load_use) begin
         state_next = bubble;
      end else begin
         state_next = captured;
      end
   end

   // Stage register; reset drops any held instruction immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= '0;
         state_reg.alu_sel <= ALU_ADD;
      end else begin
         state_reg <= state_next;
      end
   end

   // Operand forwarding: index 0 is rs1, index 1 is rs2. x0 never forwards.
   logic [1:0][RW-1:0] src_idx;
   logic [1:0][N-1:0]  src_data;
   logic [1:0][N-1:0]  fwd_data;

   assign src_idx[0]  = state_reg.rs1;
   assign src_idx[1]  = state_reg.rs2;
   assign src_data[0] = state_reg.rs1_data;
   assign src_data[1] = state_reg.rs2_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic hit_exmem;
         logic hit_memwb;
         assign hit_exmem = bus.exmem_reg_write & (bus.exmem_rd != '0) &
                            (bus.exmem_rd == src_idx[gi]);
         assign hit_memwb = bus.memwb_reg_write & (bus.memwb_rd != '0) &
                            (bus.memwb_rd == src_idx[gi]);
         assign fwd_data[gi] = hit_exmem ? bus.exmem_result :
                               hit_memwb ? bus.memwb_result : src_data[gi];
      end
   endgenerate

   assign bus.load_use_stall = load_use;
   assign bus.ex_valid       = state_reg.valid;
   assign bus.alu_a          = fwd_data[0];
   assign bus.alu_b          = state_reg.alu_src ? state_reg.imm : fwd_data[1];
   assign bus.alu_shamt      = state_reg.alu_src ? state_reg.imm[4:0] : fwd_data[1][4:0];
   assign bus.ex_store_data  = fwd_data[1];
   assign bus.alu_sel        = state_reg.alu_sel;
   assign bus.ex_rd          = state_reg.rd;
   assign bus.ex_reg_write   = state_reg.reg_write;
   assign bus.ex_mem_read    = state_reg.mem_read;
   assign bus.ex_mem_write   = state_reg.mem_write;
   assign bus.ex_pc          = state_reg.pc;
endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against an instruction-level model.
module tb_id_ex_stage;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SRA = 4'd13;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_ex_stage_if #(.N(32), .RW(5)) bus ();

   id_ex_stage #(.N(32), .RW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int vectors = 0;
   int errs    = 0;
   bit checking = 1'b0;

   // instruction held in EX, as the model sees it
   typedef struct {
      bit          valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  sel;
      bit          src, rw, mr, mw;
   } instr_t;
   instr_t m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t empty_instr();
      instr_t e;
      e.valid = 0; e.pc = 0; e.d1 = 0; e.d2 = 0; e.imm = 0;
      e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.sel = ALU_ADD;
      e.src = 0; e.rw = 0; e.mr = 0; e.mw = 0;
      return e;
   endfunction

   // a load in EX feeding a source of the instruction waiting in ID
   function automatic bit exp_lus();
      return m.valid && m.mr && m.rd != 0 && bus.id_valid &&
             (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
   endfunction

   // youngest producer wins; register 0 always reads its own data
   function automatic logic [31:0] exp_fwd(input logic [4:0] r, input logic [31:0] d);
      if (r == 0) return d;
      if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
      if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
      return d;
   endfunction

   initial m = empty_instr();

   // model: what EX holds after each edge
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m = empty_instr();
      end else if (bus.flush) begin
         m = empty_instr();
      end else if (bus.stall) begin
         // hold
      end else if (exp_lus()) begin
         m = empty_instr();
      end else begin
         m.valid = bus.id_valid;    m.pc = bus.id_pc;
         m.rs1 = bus.id_rs1;        m.rs2 = bus.id_rs2;     m.rd = bus.id_rd;
         m.d1 = bus.id_rs1_data;    m.d2 = bus.id_rs2_data; m.imm = bus.id_imm;
         m.sel = bus.id_alu_sel;    m.src = bus.id_alu_src;
         m.rw = bus.id_reg_write;   m.mr = bus.id_mem_read; m.mw = bus.id_mem_write;
      end
   end

   // compare every cycle, mid-low-phase
   always @(negedge clk) begin
      if (checking) begin
         logic [31:0] b_exp;
         b_exp = m.src ? m.imm : exp_fwd(m.rs2, m.d2);
         chk("ex_valid",      bus.ex_valid,       m.valid);
         chk("alu_a",         bus.alu_a,          exp_fwd(m.rs1, m.d1));
         chk("alu_b",         bus.alu_b,          b_exp);
         chk("alu_shamt",     bus.alu_shamt,      b_exp[4:0]);
         chk("ex_store_data", bus.ex_store_data,  exp_fwd(m.rs2, m.d2));
         chk("alu_sel",       bus.alu_sel,        m.sel);
         chk("ex_rd",         bus.ex_rd,          m.rd);
         chk("ex_reg_write",  bus.ex_reg_write,   m.rw);
         chk("ex_mem_read",   bus.ex_mem_read,    m.mr);
         chk("ex_mem_write",  bus.ex_mem_write,   m.mw);
         chk("ex_pc",         bus.ex_pc,          m.pc);
         chk("load_use",      bus.load_use_stall, exp_lus());
      end
   end

   task automatic idle_id();
      bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
      bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_alu_sel = ALU_ADD;
      bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
   endtask

   task automatic idle_fwd();
      bus.exmem_rd = 0; bus.exmem_reg_write = 0; bus.exmem_result = 0;
      bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_result = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.stall = 0; bus.flush = 0;
      idle_id(); idle_fwd();
      checking = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      // 1: asynchronous reset discards a captured instruction
      bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_rs1 = 3; bus.id_rs1_data = 32'h55;
      bus.id_rs2 = 4; bus.id_rs2_data = 32'h66; bus.id_rd = 2; bus.id_alu_sel = ALU_SRA;
      bus.id_reg_write = 1;
      step(); idle_id();
      @(negedge clk);
      chk("t1 captured valid", bus.ex_valid, 1);
      chk("t1 captured pc", bus.ex_pc, 32'h100);
      #2 rst = 1'b0;
      #1;
      chk("t1 rst ex_valid", bus.ex_valid, 0);
      chk("t1 rst alu_a", bus.alu_a, 0);
      chk("t1 rst alu_b", bus.alu_b, 0);
      chk("t1 rst alu_sel", bus.alu_sel, ALU_ADD);
      chk("t1 rst load_use", bus.load_use_stall, 0);
      @(negedge clk) rst = 1'b1;
      $display("t1 reset mid-cycle done");

      // 2: forwarding priority EX/MEM > MEM/WB > register data
      bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_data = 32'h11;
      step(); idle_id();
      bus.exmem_rd = 5; bus.exmem_result = 32'h1234; bus.exmem_reg_write = 1;
      bus.memwb_rd = 5; bus.memwb_result = 32'hAAAA; bus.memwb_reg_write = 1;
      #1 chk("t2 fwd exmem", bus.alu_a, 32'h1234);
      bus.exmem_rd = 0;
      #1 chk("t2 fwd memwb", bus.alu_a, 32'hAAAA);
      bus.memwb_reg_write = 0;
      #1 chk("t2 fwd none", bus.alu_a, 32'h11);
      idle_fwd();
      $display("t2 forward priority done");

      // 3: load-use bubble then capture
      bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rd = 7; bus.id_rs1 = 1;
      step(); idle_id();
      bus.id_valid = 1; bus.id_rs1 = 2; bus.id_rs2 = 7; bus.id_rd = 8; bus.id_reg_write = 1;
      #1 chk("t3 load_use hit", bus.load_use_stall, 1);
      step();
      chk("t3 bubble valid", bus.ex_valid, 0);
      chk("t3 bubble reg_write", bus.ex_reg_write, 0);
      chk("t3 bubble load_use", bus.load_use_stall, 0);
      step();
      chk("t3 capture valid", bus.ex_valid, 1);
      chk("t3 capture rd", bus.ex_rd, 8);
      idle_id();
      $display("t3 load-use done");

      // 4: stall holds stage state for three cycles
      bus.id_valid = 1; bus.id_rd = 9; bus.id_pc = 32'h40; bus.id_alu_sel = 4'd3; bus.id_reg_write = 1;
      step();
      bus.stall = 1;
      for (int i = 0; i < 3; i++) begin
         bus.id_rd = 5'($urandom_range(0, 31)); bus.id_pc = $urandom;
         bus.id_alu_sel = 4'($urandom_range(0, 15));
         step();
         chk("t4 hold rd", bus.ex_rd, 9);
         chk("t4 hold pc", bus.ex_pc, 32'h40);
         chk("t4 hold sel", bus.alu_sel, 4'd3);
         chk("t4 hold valid", bus.ex_valid, 1);
      end
      bus.stall = 0; bus.id_rd = 10; bus.id_pc = 32'h44;
      step();
      chk("t4 release rd", bus.ex_rd, 10);
      chk("t4 release pc", bus.ex_pc, 32'h44);
      idle_id();
      $display("t4 stall hold done");

      // 5: flush overrides stall; flush with load-use gives a single bubble
      bus.stall = 1; bus.flush = 1; bus.id_valid = 1; bus.id_pc = 32'h80; bus.id_rd = 11;
      step();
      chk("t5 flush+stall valid", bus.ex_valid, 0);
      chk("t5 flush+stall pc", bus.ex_pc, 0);
      bus.stall = 0; bus.flush = 0; idle_id();
      bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rd = 7;
      step(); idle_id();
      bus.id_valid = 1; bus.id_rs1 = 7; bus.id_rd = 12; bus.id_pc = 32'h90; bus.flush = 1;
      #1 chk("t5 load_use", bus.load_use_stall, 1);
      step(); bus.flush = 0;
      chk("t5 bubble valid", bus.ex_valid, 0);
      step();
      chk("t5 capture valid", bus.ex_valid, 1);
      chk("t5 capture pc", bus.ex_pc, 32'h90);
      idle_id();
      $display("t5 flush priority done");

      // 6: immediate operand with arithmetic shift
      bus.id_valid = 1; bus.id_alu_src = 1; bus.id_imm = 32'hFFFF_FFF0; bus.id_alu_sel = ALU_SRA;
      bus.id_rs2 = 4; bus.id_rs2_data = 32'h3;
      step(); idle_id();
      chk("t6 alu_b", bus.alu_b, 32'hFFFF_FFF0);
      chk("t6 shamt", bus.alu_shamt, 16);
      chk("t6 store_data", bus.ex_store_data, 32'h3);
      chk("t6 alu_sel", bus.alu_sel, ALU_SRA);
      $display("t6 immediate shift done");

      // randomized traffic over a small register set to exercise hazards
      for (int c = 0; c < 300; c++) begin
         bus.stall = ($urandom_range(0, 7) == 0);
         bus.flush = ($urandom_range(0, 9) == 0);
         bus.id_valid = ($urandom_range(0, 3) != 0);
         bus.id_pc = $urandom;
         bus.id_rs1 = 5'($urandom_range(0, 7)); bus.id_rs2 = 5'($urandom_range(0, 7));
         bus.id_rd = 5'($urandom_range(0, 7));
         bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
         bus.id_alu_sel = 4'($urandom_range(0, 15)); bus.id_alu_src = 1'($urandom_range(0, 1));
         bus.id_reg_write = 1'($urandom_range(0, 1));
         bus.id_mem_read = ($urandom_range(0, 2) == 0);
         bus.id_mem_write = 1'($urandom_range(0, 1));
         bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_reg_write = 1'($urandom_range(0, 1));
         bus.exmem_result = $urandom;
         bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_reg_write = 1'($urandom_range(0, 1));
         bus.memwb_result = $urandom;
         step();
         $display("rnd %0d stall=%0d flush=%0d ex_valid=%0d ex_rd=%0d alu_a=%h lus=%0d",
                  c, bus.stall, bus.flush, bus.ex_valid, bus.ex_rd, bus.alu_a, bus.load_use_stall);
      end

      bus.stall = 0; bus.flush = 0; idle_id(); idle_fwd();
      repeat (2) @(negedge clk);
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
